path_delay_ctrl: RTL

- Synthesizable cycle-based emulator of a single-bit pin-to-pin path delay. It is the clocked, runtime-configurable counterpart of a specify-block `(in => out) = (D)` path.
- Each detected input edge is scheduled onto `dout` exactly D cycles later.
- Two delay semantics: transport (every edge is delivered) or inertial (pulses shorter than D are rejected).
- Sits between a stimulus or source signal and the consumer that must see the delayed version. Config is written by the bench or a host.

---
 rtl/path_delay_pkg.sv | 20 ++
 rtl/path_delay_ctrl_edge_fifo.sv | 76 +++++++
 rtl/path_delay_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/path_delay_pkg.sv
// Shared types and reset defaults for the cycle-based pin-to-pin path delay emulator.
package path_delay_pkg;

  typedef enum logic {
    DLY_TRANSPORT = 1'b0,
    DLY_INERTIAL  = 1'b1
  } delay_mode_e;

  // Entry layout at the default 8-bit delay width; the top packs {val, due} the same way.
  localparam int ENTRY_DLY_W = 8;

  typedef struct packed {
    logic                   val;
    logic [ENTRY_DLY_W-1:0] due;
  } edge_entry_t;

  localparam int          RST_DELAY = 1;
  localparam delay_mode_e RST_MODE  = DLY_TRANSPORT;

endpackage

// File: rtl/path_delay_ctrl_edge_fifo.sv
// Circular pending-edge buffer: push/pop, tail-drop and flush, with a combinational head.
module edge_fifo #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 9,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              drop_tail,
  input  logic              flush,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  count_next,
  output logic              empty,
  output logic              full
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_pop, do_push, do_drop;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_drop = drop_tail && !do_pop && !flush && (count_q != '0);
    // A pop or a flush frees a slot in the same cycle, so a full buffer still accepts the push.
    do_push = push && !do_drop && ((count_q != FULL_CNT) || do_pop || flush);

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      count_d  = CNT_W'(do_push);
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push) - PTR_W'(do_drop);
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop) - CNT_W'(do_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: slots are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign count_next = count_d;
  assign empty      = (count_q == '0);
  assign full       = (count_q == FULL_CNT);

endmodule

// File: rtl/path_delay_ctrl.sv
// Runtime-configurable single-bit path delay: edges on din replay on dout D cycles later.
module path_delay_ctrl
  import path_delay_pkg::*;
#(
  parameter  int   DLY_W    = 8,
  parameter  int   DEPTH    = 4,
  parameter  logic INIT_VAL = 1'b0,
  localparam int   CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic             cfg_mode,
  input  logic             din,
  output logic             dout,
  output logic             busy,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             overflow,
  output logic             cfg_err
);

  localparam int ENT_W = DLY_W + 1;

  logic [DLY_W-1:0] now_q, now_d;
  logic [DLY_W-1:0] delay_q, delay_d;
  delay_mode_e      mode_q, mode_d;
  logic             last_din_q, last_din_d;
  logic             dout_q, dout_d;
  logic             overflow_q, overflow_d;
  logic             cfg_err_q, cfg_err_d;
  logic             busy_q, busy_d;

  logic             edge_det, pop, push, drop_tail, flush, dout_after_pop;
  logic             fifo_empty, fifo_full;
  logic [ENT_W-1:0] head_data, push_data;
  logic [CNT_W-1:0] fifo_count, fifo_count_next;
  logic             head_val;
  logic [DLY_W-1:0] head_due, due_new;

  assign head_val = head_data[ENT_W-1];
  assign head_due = head_data[DLY_W-1:0];

  always_comb begin
    now_d      = now_q + DLY_W'(1);
    last_din_d = din;
    edge_det   = (din != last_din_q);
    due_new    = now_q + delay_q;
    push_data  = {din, due_new};

    // Due-times are monotonic, so only the head can ever be due.
    pop            = !fifo_empty && (head_due == now_q);
    dout_after_pop = pop ? head_val : dout_q;
    dout_d         = dout_after_pop;

    push       = 1'b0;
    drop_tail  = 1'b0;
    flush      = 1'b0;
    overflow_d = overflow_q;

    if (edge_det) begin
      if (mode_q == DLY_TRANSPORT) begin
        // Dropping the tail collapses the newest pulse; entries alternate so the final level survives.
        if (fifo_full && !pop) begin
          drop_tail  = 1'b1;
          overflow_d = 1'b1;
        end else begin
          push = 1'b1;
        end
      end else begin
        flush = 1'b1;
        push  = (din != dout_after_pop);
      end
    end

    delay_d   = delay_q;
    mode_d    = mode_q;
    cfg_err_d = 1'b0;

    // Config only changes while idle, which keeps queued due-times in order.
    if (cfg_we) begin
      if (busy_q) begin
        cfg_err_d = 1'b1;
      end else begin
        mode_d     = delay_mode_e'(cfg_mode);
        overflow_d = 1'b0;
        if (cfg_delay == '0) begin
          delay_d   = DLY_W'(1);
          cfg_err_d = 1'b1;
        end else begin
          delay_d = cfg_delay;
        end
      end
    end

    busy_d = (fifo_count_next != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      now_q      <= '0;
      delay_q    <= DLY_W'(RST_DELAY);
      mode_q     <= RST_MODE;
      last_din_q <= INIT_VAL;
      dout_q     <= INIT_VAL;
      overflow_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      now_q      <= now_d;
      delay_q    <= delay_d;
      mode_q     <= mode_d;
      last_din_q <= last_din_d;
      dout_q     <= dout_d;
      overflow_q <= overflow_d;
      cfg_err_q  <= cfg_err_d;
      busy_q     <= busy_d;
    end
  end

  edge_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ENT_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .drop_tail  (drop_tail),
    .flush      (flush),
    .head_data  (head_data),
    .count      (fifo_count),
    .count_next (fifo_count_next),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  assign dout        = dout_q;
  assign busy        = busy_q;
  assign pending_cnt = fifo_count;
  assign overflow    = overflow_q;
  assign cfg_err     = cfg_err_q;

endmodule
